// File: rtl/soc_pio_pkg.sv
// Shared constants for the soc_system PIO slaves: register word addresses and edge-mode encodings.
package soc_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    localparam int unsigned PIO_EDGE_RISE = 0;
    localparam int unsigned PIO_EDGE_FALL = 1;
    localparam int unsigned PIO_EDGE_ANY  = 2;

endpackage

// File: rtl/soc_pio_debounce.sv
// Single-bit debouncer: output follows input only after DEBOUNCE_CYCLES consecutive differing cycles.
// Latency: exactly DEBOUNCE_CYCLES clocks on a clean transition; shorter glitches never reach the output.
module soc_pio_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic dout_o
);
    localparam int unsigned   CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (din_i == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = din_i;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign dout_o = stable_q;

endmodule

// File: rtl/soc_switch_pio_irq.sv
// Avalon-MM input PIO: synchronised switches, sticky W1C edge capture, masked level irq; 1-clock read latency.
// SWITCH_PIO_DEBOUNCE_EN inserts a per-bit debouncer between the synchroniser and the filtered value.
module soc_switch_pio_irq
    import soc_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned EDGE_MODE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] edge_det;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain_q <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

`ifdef SWITCH_PIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        soc_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .din_i  (sync_q[i]),
            .dout_o (filt_q[i])
        );
    end
    assign unused_ok = ^{writedata, 1'b0};
`else
    assign filt_q    = sync_q;
    assign unused_ok = ^{writedata, 1'b0} ^ (DEBOUNCE_CYCLES == 0);
`endif

    always_comb begin
        case (EDGE_MODE)
            PIO_EDGE_RISE: edge_det = filt_q & ~prev_q;
            PIO_EDGE_FALL: edge_det = ~filt_q & prev_q;
            PIO_EDGE_ANY:  edge_det = filt_q ^ prev_q;
            default:       edge_det = '0;
        endcase
    end

    assign wr_en = chipselect & ~write_n;

    // A capture in the same cycle as its W1C survives: the set term is ORed after the clear.
    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        if (wr_en && address == PIO_ADDR_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == PIO_ADDR_EDGE) begin
            edge_d = edge_q & ~writedata[WIDTH-1:0];
        end
        edge_d = edge_d | edge_det;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            PIO_ADDR_DATA: readdata_d[WIDTH-1:0] = filt_q;
            PIO_ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
            PIO_ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= filt_q;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule
